regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (write address, write data, write enable) between two writeback requesters: requester 0 (load/memory return) and requester 1 (ALU result). Each requester has a one-entry holding buffer with a valid/ready handshake. One buffered write is granted per cycle and presented to the register file as a registered write. Writes to register 0 are accepted and discarded, because that register is hard-wired to zero.

---
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the two writeback requesters and the register file.
// master = requester/register-file side, slave = regfile_write_arbiter.
interface regfile_write_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_addr;
  logic [15:0] req1_data;
  logic [1:0]  wr;
  logic [15:0] wd;
  logic        regwrite;
  logic        busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr, wd, regwrite, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr, wd, regwrite, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file's single write port, one-entry buffer per requester.
// Define REGFILE_ARB_RR_EN for round-robin; otherwise buf0 (load) has fixed priority.
module regfile_write_arbiter (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam int ADDR_W = 2;
  localparam int DATA_W = 16;

  logic              buf0_valid_q, buf0_valid_d;
  logic [ADDR_W-1:0] buf0_addr_q,  buf0_addr_d;
  logic [DATA_W-1:0] buf0_data_q,  buf0_data_d;
  logic              buf1_valid_q, buf1_valid_d;
  logic [ADDR_W-1:0] buf1_addr_q,  buf1_addr_d;
  logic [DATA_W-1:0] buf1_data_q,  buf1_data_d;
  logic [ADDR_W-1:0] wr_q,         wr_d;
  logic [DATA_W-1:0] wd_q,         wd_d;
  logic              regwrite_q,   regwrite_d;
`ifdef REGFILE_ARB_RR_EN
  logic              prio_q,       prio_d;
`endif

  logic grant0, grant1;
  logic ready0, ready1;
  logic load0, load1;

  always_comb begin
`ifdef REGFILE_ARB_RR_EN
    grant0 = buf0_valid_q & (~buf1_valid_q | ~prio_q);
`else
    grant0 = buf0_valid_q;
`endif
    grant1 = buf1_valid_q & ~grant0;

    // Ready is a function of registered state only; reset just masks it.
    ready0 = ~reset & (~buf0_valid_q | grant0);
    ready1 = ~reset & (~buf1_valid_q | grant1);

    // Register 0 is hard-wired: such writes are handshaken but never buffered.
    load0 = bus.req0_valid & ready0 & (bus.req0_addr != '0);
    load1 = bus.req1_valid & ready1 & (bus.req1_addr != '0);

    buf0_valid_d = load0 | (buf0_valid_q & ~grant0);
    buf0_addr_d  = load0 ? bus.req0_addr : buf0_addr_q;
    buf0_data_d  = load0 ? bus.req0_data : buf0_data_q;
    buf1_valid_d = load1 | (buf1_valid_q & ~grant1);
    buf1_addr_d  = load1 ? bus.req1_addr : buf1_addr_q;
    buf1_data_d  = load1 ? bus.req1_data : buf1_data_q;

    wr_d       = wr_q;
    wd_d       = wd_q;
    regwrite_d = grant0 | grant1;
    if (grant0) begin
      wr_d = buf0_addr_q;
      wd_d = buf0_data_q;
    end else if (grant1) begin
      wr_d = buf1_addr_q;
      wd_d = buf1_data_q;
    end

`ifdef REGFILE_ARB_RR_EN
    // On a contested grant the pointer moves to the loser.
    prio_d = prio_q;
    if (buf0_valid_q & buf1_valid_q) prio_d = grant0;
`endif
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.wr         = wr_q;
  assign bus.wd         = wd_q;
  assign bus.regwrite   = regwrite_q;
  assign bus.busy       = buf0_valid_q | buf1_valid_q | regwrite_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      buf0_valid_q <= 1'b0;
      buf1_valid_q <= 1'b0;
      regwrite_q   <= 1'b0;
      wr_q         <= '0;
      wd_q         <= '0;
`ifdef REGFILE_ARB_RR_EN
      prio_q       <= 1'b0;
`endif
    end else begin
      buf0_valid_q <= buf0_valid_d;
      buf1_valid_q <= buf1_valid_d;
      regwrite_q   <= regwrite_d;
      wr_q         <= wr_d;
      wd_q         <= wd_d;
`ifdef REGFILE_ARB_RR_EN
      prio_q       <= prio_d;
`endif
    end
  end

  // Buffer payload is qualified by its valid bit and needs no reset.
  always_ff @(posedge clock) begin
    buf0_addr_q <= buf0_addr_d;
    buf0_data_q <= buf0_data_d;
    buf1_addr_q <= buf1_addr_d;
    buf1_data_q <= buf1_data_d;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: queue-based reference model pushes the expected
// write-port state per cycle, a negedge monitor pops and compares it against the DUT.
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus();
  regfile_write_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct { bit rw; logic [1:0] a; logic [15:0] d; } exp_t;
  typedef struct { logic [1:0] a; logic [15:0] d; } ent_t;

  exp_t sb[$];
  ent_t pend0[$];
  ent_t pend1[$];
  bit          m_prio;
  bit          m_last_rw;
  logic [1:0]  m_wr;
  logic [15:0] m_wd;
  logic [15:0] rf_ref [4];
  logic [15:0] rf_dut [4];

  int n_cmp = 0;
  int n_err = 0;
  bit started = 0;
  bit rst_i = 1;

  bit          s0_v = 0, s1_v = 0;
  logic [1:0]  s0_a = 0, s1_a = 0;
  logic [15:0] s0_d = 0, s1_d = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Which pending write the arbitration rules pick this cycle (-1 = none).
  function automatic int winner();
    if (pend0.size() != 0 && pend1.size() != 0) begin
`ifdef REGFILE_ARB_RR_EN
      return m_prio ? 1 : 0;
`else
      return 0;
`endif
    end
    if (pend0.size() != 0) return 0;
    if (pend1.size() != 0) return 1;
    return -1;
  endfunction

  function automatic bit exp_ready(int n);
    int w;
    if (rst_i) return 1'b0;
    w = winner();
    if (n == 0) return (pend0.size() == 0) || (w == 0);
    return (pend1.size() == 0) || (w == 1);
  endfunction

  task automatic step(input bit r);
    int   w;
    bit   a0, a1, both;
    ent_t e;
    @(negedge clock);
    rst_i          = r;
    reset          = r;
    bus.req0_valid = s0_v;
    bus.req0_addr  = s0_a;
    bus.req0_data  = s0_d;
    bus.req1_valid = s1_v;
    bus.req1_addr  = s1_a;
    bus.req1_data  = s1_d;
    #1;
    if (started) begin
      chk("req0_ready", 32'(bus.req0_ready), 32'(exp_ready(0)));
      chk("req1_ready", 32'(bus.req1_ready), 32'(exp_ready(1)));
      chk("busy", 32'(bus.busy),
          32'((pend0.size() != 0) || (pend1.size() != 0) || m_last_rw));
    end
    @(posedge clock);
    w    = winner();
    a0   = s0_v && exp_ready(0);
    a1   = s1_v && exp_ready(1);
    both = (pend0.size() != 0) && (pend1.size() != 0);
    if (r) begin
      pend0.delete();
      pend1.delete();
      m_prio    = 0;
      m_wr      = 0;
      m_wd      = 0;
      m_last_rw = 0;
      sb.push_back('{rw: 1'b0, a: 2'd0, d: 16'd0});
    end else begin
      if (w >= 0) begin
        e = (w == 0) ? pend0.pop_front() : pend1.pop_front();
        m_wr = e.a;
        m_wd = e.d;
        rf_ref[e.a] = e.d;
        m_last_rw = 1;
        if (both) m_prio = (w == 0);
      end else begin
        m_last_rw = 0;
      end
      sb.push_back('{rw: m_last_rw, a: m_wr, d: m_wd});
      if (a0 && s0_a != 2'd0) pend0.push_back('{a: s0_a, d: s0_d});
      if (a1 && s1_a != 2'd0) pend1.push_back('{a: s1_a, d: s1_d});
    end
    if (a0) s0_v = 0;
    if (a1) s1_v = 0;
    started = 1;
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((s0_v || s1_v || pend0.size() != 0 || pend1.size() != 0) && k < maxc) begin
      step(0);
      k++;
    end
    if (k >= maxc) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: still pending after %0d cycles", maxc);
    end
    repeat (2) step(0);
  endtask

  exp_t me;
  always @(negedge clock) begin
    if (started) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
        me = sb.pop_front();
        chk("regwrite", 32'(bus.regwrite), 32'(me.rw));
        chk("wr", 32'(bus.wr), 32'(me.a));
        chk("wd", 32'(bus.wd), 32'(me.d));
      end
      if (bus.regwrite === 1'b1) rf_dut[bus.wr] = bus.wd;
    end
  end

  initial begin
    int k;
    reset          = 1;
    bus.req0_valid = 0;
    bus.req0_addr  = 0;
    bus.req0_data  = 0;
    bus.req1_valid = 0;
    bus.req1_addr  = 0;
    bus.req1_data  = 0;
    for (int i = 0; i < 4; i++) begin
      rf_ref[i] = 0;
      rf_dut[i] = 0;
    end
    repeat (3) step(1);

    // Single uncontested write.
    s1_v = 1; s1_a = 2'd2; s1_d = 16'hBEEF;
    drain(10);

    // Write to register 0 is accepted and dropped.
    s0_v = 1; s0_a = 2'd0; s0_d = 16'h1234;
    drain(10);

    // Same-register conflict straight after reset.
    step(1);
    s0_v = 1; s0_a = 2'd3; s0_d = 16'h0001;
    s1_v = 1; s1_a = 2'd3; s1_d = 16'h0002;
    drain(10);
    chk("rf3_final", 32'(rf_dut[3]), 32'h0002);
    chk("rf3_ref", 32'(rf_dut[3]), 32'(rf_ref[3]));

    // Back-to-back stream from requester 1.
    for (int i = 1; i <= 3; i++) begin
      s1_v = 1; s1_a = 2'(i); s1_d = 16'(16'h0100 + i);
      k = 0;
      do begin step(0); k++; end while (s1_v && k < 5);
    end
    drain(10);

    // Continuous contention with non-zero addresses.
    step(1);
    for (int i = 0; i < 200; i++) begin
      if (!s0_v) begin s0_v = 1; s0_a = 2'($urandom_range(1, 3)); s0_d = 16'($urandom); end
      if (!s1_v) begin s1_v = 1; s1_a = 2'($urandom_range(1, 3)); s1_d = 16'($urandom); end
      step(0);
    end
    drain(10);

    // Mixed random traffic, including register 0 and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if (!s0_v && $urandom_range(0, 2) != 0) begin
        s0_v = 1; s0_a = 2'($urandom_range(0, 3)); s0_d = 16'($urandom);
      end
      if (!s1_v && $urandom_range(0, 2) != 0) begin
        s1_v = 1; s1_a = 2'($urandom_range(0, 3)); s1_d = 16'($urandom);
      end
      step($urandom_range(0, 99) == 0);
    end
    drain(10);

    // Reset with both buffers full.
    step(1);
    s0_v = 1; s0_a = 2'd1; s0_d = 16'hAAAA;
    s1_v = 1; s1_a = 2'd2; s1_d = 16'h5555;
    step(0);
    s0_v = 0; s1_v = 0;
    step(1);
    repeat (3) step(0);

`ifndef REGFILE_ARB_RR_EN
    // Fixed priority: continuous load traffic starves requester 1.
    step(1);
    s1_v = 1; s1_a = 2'd3; s1_d = 16'h7777;
    for (int i = 0; i < 50; i++) begin
      if (!s0_v) begin s0_v = 1; s0_a = 2'($urandom_range(1, 3)); s0_d = 16'($urandom); end
      step(0);
      if (i > 0) chk("starve_ready1", 32'(bus.req1_ready), 32'(0));
    end
    drain(10);
`endif

    @(negedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
